// File: rtl/ee357_mcpu_memresp.sv
// ee357_mcpu_memresp
// Memory responder for the EE357 multicycle CPU. It accepts a single read or write
// request, waits a fixed number of cycles, then answers with a one-cycle rdy strobe.
// While rdy is high, err tells the requester whether the access was refused.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   mr, mw     read / write request levels; the requester holds them until rdy
//   addr       byte address; only the word index bits select storage
//   wdata      write data, sampled together with the request
//   rdata      registered read data; it changes only on a read or error response
//   rdy        registered one-cycle response strobe
//   err        registered error flag, meaningful only while rdy is high
//   state_dbg  current FSM state (0 IDLE, 1 BUSY, 2 RESP, 3 HOLD)
//
// Handshake: a request is taken in IDLE when mr or mw is high at a clock edge.
// The values at that edge are latched, and later changes on the inputs are ignored.
// rdy is high for exactly one cycle, WAIT_CYCLES+1 cycles after the capture edge.
// The FSM then waits in HOLD until it samples mr and mw both low. Only after that
// can a new request be accepted.
module ee357_mcpu_memresp #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mr,
    input  logic        mw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdy,
    output logic        err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  err_cap_q, err_cap_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rdy_q, rdy_d;
    logic                  err_q, err_d;

    logic [31:0]           mem [2**DEPTH_LOG2];

    logic                  req;
    logic                  req_err;
    logic                  enter_resp;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic                  acc_wr;
    logic                  acc_err;
    logic                  mem_we;
    logic                  unused_addr;

    // Address bits above the word index are not decoded, so addresses alias.
    assign unused_addr = ^addr[31:DEPTH_LOG2+2];

    assign req     = mr | mw;
    assign req_err = (addr[1:0] != 2'b00) | (mr & mw);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        err_cap_d  = err_cap_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d     = addr[DEPTH_LOG2+1:2];
                    wdata_d   = wdata;
                    wr_d      = mw;
                    err_cap_d = req_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        cnt_d      = 4'd0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = HOLD;
            HOLD: begin
                if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // When WAIT_CYCLES is 0, RESP is entered on the capture edge itself.
        // In that case the access is taken from the live inputs, not from the
        // capture registers.
        if (state_q == IDLE) begin
            acc_idx   = addr[DEPTH_LOG2+1:2];
            acc_wdata = wdata;
            acc_wr    = mw;
            acc_err   = req_err;
        end else begin
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_wr    = wr_q;
            acc_err   = err_cap_q;
        end

        if (enter_resp) begin
            if (acc_err)      rdata_d = 32'd0;
            else if (!acc_wr) rdata_d = mem[acc_idx];
        end

        // rdy and err are delayed by one register stage after RESP.
        // This gives the WAIT_CYCLES+1 latency.
        rdy_d  = (state_q == RESP);
        err_d  = (state_q == RESP) & err_cap_q;
        mem_we = enter_resp & acc_wr & ~acc_err & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            wr_q      <= 1'b0;
            err_cap_q <= 1'b0;
            rdata_q   <= 32'd0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            err_cap_q <= err_cap_d;
            rdata_q   <= rdata_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[acc_idx] <= acc_wdata;
    end

    assign rdata     = rdata_q;
    assign rdy       = rdy_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ee357_mcpu_memresp.sv
// Bench for ee357_mcpu_memresp with WAIT_CYCLES=2 and DEPTH_LOG2=8.
// Expected {err, rdata} responses are queued when a request is driven.
// The monitor pops and compares them when rdy appears.
module tb_ee357_mcpu_memresp;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        mr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdy;
    logic        err;
    logic [1:0]  state_dbg;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [32:0] exp_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] last_rdata;

    ee357_mcpu_memresp #(.WAIT_CYCLES(W), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst), .mr(mr), .mw(mw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdy(rdy), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && rdy) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL resp_unexpected: got rdy err=%0b rdata=%08h, required no response", err, rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({err, rdata} !== e)
                    begin
                        err_cnt++;
                        $display("FAIL resp_data: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                                 err, rdata, e[32], e[31:0]);
                    end
            end
        end
    end

    // ---------------- driver ----------------
    // Drives one request and queues its expected response.
    // It waits (bounded) for rdy and returns the number of cycles from the capture
    // edge to rdy. Inputs are scrambled while the access is in flight.
    // If drop is set, the requests are lowered as soon as rdy is seen.
    task automatic issue(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit drop, output int lat);
        logic       e;
        logic [31:0] exp_rd;
        bit got;
        e = (a[1:0] != 2'b00) || (r && w);
        if (e) exp_rd = 32'd0;
        else if (w) begin
            exp_rd = last_rdata;
            model_mem[a[9:2]] = d;
        end else exp_rd = model_mem[a[9:2]];
        last_rdata = exp_rd;
        @(negedge clk);
        mr = r; mw = w; addr = a; wdata = d;
        exp_q.push_back({e, exp_rd});
        @(posedge clk);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (rdy) got = 1;
            else begin
                addr = $urandom;
                wdata = $urandom;
            end
        end
        if (!got) begin
            err_cnt++;
            $display("FAIL rdy_timeout: no rdy within %0d cycles for addr=%08h", lat, a);
            void'(exp_q.pop_back());
            lat = -1;
        end
        if (drop) begin
            mr = 1'b0;
            mw = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; mr = 1'b0; mw = 1'b0; addr = 32'd0; wdata = 32'd0;
        last_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (rdy !== 1'b0) begin err_cnt++; $display("FAIL reset_rdy: got %0b required 0", rdy); end
        chk_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %0b required 0", err); end
        chk_cnt++; if (rdata !== 32'd0) begin err_cnt++; $display("FAIL reset_rdata: got %08h required 0", rdata); end
        chk_cnt++; if (state_dbg !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat;
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, lat);
        chk_cnt++; if (lat != W + 1) begin err_cnt++; $display("FAIL wr_latency: got %0d required %0d", lat, W + 1); end
        @(posedge clk); #1;
        chk_cnt++; if (rdy !== 1'b0) begin err_cnt++; $display("FAIL rdy_one_cycle: got %0b required 0", rdy); end
        chk_cnt++; if (state_dbg !== 2'd0) begin err_cnt++; $display("FAIL back_to_idle: got %0d required 0", state_dbg); end
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, lat);
        chk_cnt++; if (lat != W + 1) begin err_cnt++; $display("FAIL rd_latency: got %0d required %0d", lat, W + 1); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        int lat;
        issue(1'b0, 1'b1, 32'h20, 32'h11112222, 1'b1, lat);
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, lat);
        @(posedge clk); #1;
        chk_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL err_clears: got %0b required 0", err); end
        issue(1'b1, 1'b1, 32'h20, 32'h00000BAD, 1'b1, lat);
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, lat);
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_alias();
        int lat;
        issue(1'b0, 1'b1, 32'h0, 32'h12345678, 1'b1, lat);
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        int lat;
        int rdy_seen;
        issue(1'b0, 1'b1, 32'h8, 32'h01020304, 1'b1, lat);
        @(posedge clk); #1;
        @(negedge clk);
        mw = 1'b1; addr = 32'h8; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        chk_cnt++; if (state_dbg !== 2'd1) begin err_cnt++; $display("FAIL busy_state: got %0d required 1", state_dbg); end
        @(negedge clk);
        rst = 1'b1; mw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 32'd0;
        chk_cnt++; if (rdata !== 32'd0) begin err_cnt++; $display("FAIL rst_busy_rdata: got %08h required 0", rdata); end
        rdy_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy) rdy_seen++;
        end
        chk_cnt++; if (rdy_seen != 0) begin err_cnt++; $display("FAIL rst_busy_no_rdy: got %0d pulses required 0", rdy_seen); end
        issue(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int lat;
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        chk_cnt++; if (lat != W + 1) begin err_cnt++; $display("FAIL hold_latency: got %0d required %0d", lat, W + 1); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (rdy !== 1'b0 || state_dbg !== 2'd3) begin
                err_cnt++;
                $display("FAIL hold_stay: cycle %0d got rdy=%0b state=%0d required rdy=0 state=3", i, rdy, state_dbg);
            end
        end
        mr = 1'b0;
        @(posedge clk); #1;
        chk_cnt++; if (state_dbg !== 2'd0) begin err_cnt++; $display("FAIL hold_release: got %0d required 0", state_dbg); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] a;
        logic r;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 1'b1, 32'h40 + 32'(i * 4), $urandom, 1'b1, lat);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 16; i++) begin
            a = 32'h40 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            r = 1'($urandom_range(0, 1));
            issue(r, ~r, a, $urandom, 1'b1, lat);
            chk_cnt++; if (lat != W + 1) begin err_cnt++; $display("FAIL b2b_latency: op %0d got %0d required %0d", i, lat, W + 1); end
            @(posedge clk); #1;
            chk_cnt++; if (state_dbg !== 2'd0) begin err_cnt++; $display("FAIL b2b_idle: op %0d got %0d required 0", i, state_dbg); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_alias();
        test_reset_busy();
        test_hold();
        test_back_to_back();
        repeat (4) @(posedge clk);
        chk_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL pending_responses: got %0d outstanding required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ee357_mcpu_memresp.md
EE357_MCPU_MEMRESP -- requirements
Module: ee357_mcpu_memresp

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait cycles between request capture and response (0..15).
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of word count of internal storage.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mr  input  1  memory read request, level, held by requester until rdy.
REQ-006 mw  input  1  memory write request, level, held by requester until rdy.
REQ-007 addr  input  32  byte address of access.
REQ-008 wdata  input  32  write data, valid while mw high.
REQ-009 rdata  output  32  registered read data.
REQ-010 rdy  output  1  registered one-cycle response strobe.
REQ-011 err  output  1  registered error flag, qualified by rdy.

Function
REQ-012 Storage SHALL be 2**DEPTH_LOG2 words of 32 bits, indexed by addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliasing/wrap).
REQ-013 FSM states SHALL be IDLE, BUSY, RESP, HOLD.
REQ-014 IDLE: on mr or mw high, SHALL capture addr, wdata, operation and check for error, then go BUSY with counter = WAIT_CYCLES, or directly to RESP if WAIT_CYCLES = 0.
REQ-015 Error condition: addr[1:0] != 0, or mr and mw both high at capture.
REQ-016 BUSY: counter SHALL decrement each cycle; when counter reaches 1, next state RESP.
REQ-017 On the edge entering RESP, a valid write SHALL commit captured wdata to storage; a valid read SHALL load rdata from storage.
REQ-018 On error, storage SHALL NOT be modified and rdata SHALL load 0.
REQ-019 RESP: rdy = 1 for exactly one cycle; err = 1 iff error captured; next state HOLD.
REQ-020 HOLD: rdy = 0; SHALL remain until mr = 0 and mw = 0 sampled, then go IDLE; no new request accepted in HOLD.
REQ-021 Latency: rdy SHALL be high exactly WAIT_CYCLES+1 cycles after the edge where IDLE samples the request.
REQ-022 Changes to mr, mw, addr, wdata after capture and before IDLE SHALL be ignored.
REQ-023 rdata SHALL hold its value until the next read or error response loads it; a write response leaves rdata unchanged.
REQ-024 err SHALL return to 0 the cycle after RESP.
REQ-025 Read-after-write to the same word SHALL return the written data.
REQ-026 Back-to-back requests: minimum spacing IDLE to IDLE is WAIT_CYCLES+3 cycles including one HOLD cycle with requests low.

Reset
REQ-027 rst high at a clock edge SHALL force state IDLE, counter 0, rdy 0, err 0, rdata 0.
REQ-028 rst SHALL take priority over all transitions; storage contents SHALL NOT be cleared by reset.
REQ-029 rst asserted in BUSY SHALL abandon the access; the pending write SHALL NOT commit.
REQ-030 After rst deasserts, a request still held high SHALL be captured as a new request in IDLE.

Verification
REQ-031 WAIT_CYCLES=2: mw=1, addr=0x10, wdata=0xDEADBEEF -> rdy high 3 cycles after capture, err=0; drop mw; then mr=1, addr=0x10 -> rdata=0xDEADBEEF with rdy.
REQ-032 mr=1, addr=0x13 -> rdy with err=1, rdata=0; storage unchanged.
REQ-033 mr=1 and mw=1, addr=0x20 -> rdy with err=1; subsequent read of 0x20 returns its prior value.
REQ-034 Write 0x12345678 to addr 0x0, then read addr 0x400 (DEPTH_LOG2=8) -> rdata=0x12345678 (alias).
REQ-035 mw=1, addr=0x8, wdata=0xA5A5A5A5, rst pulsed during BUSY -> no rdy; subsequent read of 0x8 returns prior value.
REQ-036 mr held high 5 cycles past rdy -> exactly one rdy pulse; FSM stays HOLD until mr drops, then IDLE.
